// File: rtl/hdr_pkg.sv
// hdr_pkg: shared descriptor layout, defaults and FSM encoding for the HDR command fetcher.
package hdr_pkg;
   localparam logic [11:0] CMD_BASE = 12'd100;
   localparam int          MAX_CMDS = 8;
   localparam logic [2:0]  HDR_MODE = 3'd6;
   localparam int CP_BIT   = 7;
   localparam int TOC_BIT  = 6;
   localparam int MODE_MSB = 5;
   localparam int MODE_LSB = 3;
   typedef struct packed {
      logic       cp;
      logic       toc;
      logic [2:0] mode;
      logic [7:0] ccc;
   } desc_t;
   typedef enum logic [2:0] {
      S_IDLE,
      S_RD0,
      S_W0,
      S_RD1,
      S_W1,
      S_LAUNCH,
      S_RUN
   } state_t;
endpackage

// File: rtl/hdr_desc_reg.sv
// hdr_desc_reg: active/shadow descriptor pair with byte loads, promotion and shadow-valid flag.
module hdr_desc_reg
   import hdr_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clr,
   input  logic       i_ld0,
   input  logic       i_ld1,
   input  logic       i_to_sh,
   input  logic       i_force_toc,
   input  logic       i_promote,
   input  logic [7:0] i_data,
   output desc_t      o_act,
   output desc_t      o_sh,
   output logic       o_sh_vld
);
   desc_t act_q, act_d, sh_q, sh_d, tgt;
   logic  vld_q, vld_d;

   always_comb begin
      act_d = act_q;
      sh_d  = sh_q;
      vld_d = vld_q;
      tgt   = i_to_sh ? sh_q : act_q;
      if (i_ld0) begin
         tgt.cp   = i_data[CP_BIT];
         tgt.toc  = i_data[TOC_BIT] | i_force_toc;
         tgt.mode = i_data[MODE_MSB:MODE_LSB];
      end
      if (i_ld1) tgt.ccc = i_data;
      if ((i_ld0 | i_ld1) & i_to_sh) sh_d = tgt;
      if ((i_ld0 | i_ld1) & ~i_to_sh) act_d = tgt;
      if (i_ld1 & i_to_sh) vld_d = 1'b1;
      if (i_promote) begin
         act_d = sh_q;
         vld_d = 1'b0;
      end
      if (i_clr) begin
         act_d = '0;
         sh_d  = '0;
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         act_q <= '0;
         sh_q  <= '0;
         vld_q <= 1'b0;
      end else begin
         act_q <= act_d;
         sh_q  <= sh_d;
         vld_q <= vld_d;
      end
   end

   assign o_act    = act_q;
   assign o_sh     = sh_q;
   assign o_sh_vld = vld_q;
endmodule

// File: rtl/hdr_cmd_fetch.sv
// hdr_cmd_fetch: reads HDR command descriptors from the register file and feeds the HDR engine,
// prefetching the next descriptor so CP/TOC are ready at each CCC/DDR done.
module hdr_cmd_fetch
   import hdr_pkg::*;
(
   input  logic        i_sys_clk,
   input  logic        i_sys_rst_n,
   input  logic        i_fetch_start,
   input  logic [3:0]  i_cmd_count,
   input  logic [7:0]  i_regf_rd_data,
   output logic        o_regf_rd_en,
   output logic [11:0] o_regf_addr,
   input  logic        i_ccc_done,
   input  logic        i_ddr_mode_done,
   input  logic        i_hdrengine_done,
   output logic        o_hdrengine_en,
   output logic        o_cp,
   output logic        o_toc,
   output logic [2:0]  o_mode,
   output logic [7:0]  o_ccc_code,
   output logic [2:0]  o_tid,
   output logic        o_fetch_done,
   output logic        o_fetch_err
);
   state_t     state_q, state_d;
   logic       pf_q, pf_d;
   logic [3:0] last_q, last_d, fseq_q, fseq_d;
   logic [2:0] fptr_q, fptr_d, tid_q, tid_d, mode_q, mode_d;
   logic       en_q, en_d, cp_q, cp_d, toc_q, toc_d, done_q, done_d, err_q, err_d;
   logic [7:0] ccc_q, ccc_d;
   logic       clr, promote, evt;
   logic [2:0] fptr_nx;
   desc_t      act, sh;
   logic       sh_vld;

   assign fptr_nx = (fptr_q == 3'(MAX_CMDS - 1)) ? 3'd0 : fptr_q + 3'd1;
   assign evt     = i_ccc_done | i_ddr_mode_done;

   hdr_desc_reg u_desc (
      .i_clk       (i_sys_clk),
      .i_rst_n     (i_sys_rst_n),
      .i_clr       (clr),
      .i_ld0       (state_q == S_W0),
      .i_ld1       (state_q == S_W1),
      .i_to_sh     (pf_q),
      .i_force_toc (fseq_q == last_q),
      .i_promote   (promote),
      .i_data      (i_regf_rd_data),
      .o_act       (act),
      .o_sh        (sh),
      .o_sh_vld    (sh_vld)
   );

   always_comb begin
      state_d = state_q;
      pf_d    = pf_q;
      last_d  = last_q;
      fseq_d  = fseq_q;
      fptr_d  = fptr_q;
      tid_d   = tid_q;
      mode_d  = mode_q;
      en_d    = en_q;
      cp_d    = cp_q;
      toc_d   = toc_q;
      ccc_d   = ccc_q;
      err_d   = err_q;
      done_d  = 1'b0;
      clr     = 1'b0;
      promote = 1'b0;
      case (state_q)
         S_IDLE: if (i_fetch_start) begin
            clr     = 1'b1;
            err_d   = 1'b0;
            last_d  = (i_cmd_count == 4'd0) ? 4'd0 : i_cmd_count - 4'd1;
            fseq_d  = 4'd0;
            fptr_d  = 3'd0;
            pf_d    = 1'b0;
            state_d = S_RD0;
         end
         S_RD0: state_d = S_W0;
         S_W0: state_d = S_RD1;
         S_RD1: state_d = S_W1;
         S_W1: state_d = pf_q ? S_RUN : S_LAUNCH;
         S_LAUNCH: begin
            en_d    = 1'b1;
            cp_d    = act.cp;
            toc_d   = act.toc;
            mode_d  = act.mode;
            ccc_d   = act.ccc;
            tid_d   = fptr_q;
            state_d = S_RUN;
            if (!act.toc) begin
               pf_d    = 1'b1;
               fseq_d  = fseq_q + 4'd1;
               fptr_d  = fptr_nx;
               state_d = S_RD0;
            end
         end
         default: ;
      endcase
      // While the engine runs, its events override the fetch walk (including an in-flight prefetch).
      if (en_q) begin
         if (sh_vld) cp_d = sh.cp;
         if (i_hdrengine_done) begin
            en_d    = 1'b0;
            done_d  = ~err_q;
            pf_d    = 1'b0;
            state_d = S_IDLE;
         end else if (evt && !act.toc) begin
            if (sh_vld) begin
               promote = 1'b1;
               cp_d    = sh.cp;
               toc_d   = sh.toc;
               mode_d  = sh.mode;
               ccc_d   = sh.ccc;
               tid_d   = fptr_q;
               if (!sh.toc) begin
                  pf_d    = 1'b1;
                  fseq_d  = fseq_q + 4'd1;
                  fptr_d  = fptr_nx;
                  state_d = S_RD0;
               end
            end else begin
               err_d   = 1'b1;
               en_d    = 1'b0;
               pf_d    = 1'b0;
               state_d = S_IDLE;
            end
         end
      end
   end

   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         state_q <= S_IDLE;
         pf_q    <= 1'b0;
         last_q  <= 4'd0;
         fseq_q  <= 4'd0;
         fptr_q  <= 3'd0;
         tid_q   <= 3'd0;
         mode_q  <= 3'd0;
         en_q    <= 1'b0;
         cp_q    <= 1'b0;
         toc_q   <= 1'b0;
         ccc_q   <= 8'd0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pf_q    <= pf_d;
         last_q  <= last_d;
         fseq_q  <= fseq_d;
         fptr_q  <= fptr_d;
         tid_q   <= tid_d;
         mode_q  <= mode_d;
         en_q    <= en_d;
         cp_q    <= cp_d;
         toc_q   <= toc_d;
         ccc_q   <= ccc_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign o_regf_rd_en   = (state_q == S_RD0) | (state_q == S_RD1);
   assign o_regf_addr    = CMD_BASE + {8'd0, fptr_q, 1'b0} + {11'd0, state_q == S_RD1};
   assign o_hdrengine_en = en_q;
   assign o_cp           = cp_q;
   assign o_toc          = toc_q;
   assign o_mode         = mode_q;
   assign o_ccc_code     = ccc_q;
   assign o_tid          = tid_q;
   assign o_fetch_done   = done_q;
   assign o_fetch_err    = err_q;
endmodule

// File: doc/hdr_cmd_fetch.md
Name: hdr_cmd_fetch

Overview:
- Upstream feeder of the HDR engine. On start from the I3C engine, it reads HDR command descriptors from the register file and decodes them.
- It drives the HDR engine enable/CP/TOC/MODE inputs and prefetches the next descriptor, so that CP/TOC are valid when the engine samples them at each CCC/DDR done.
- It reports sequence completion or error back to the I3C engine.

Parameters:
- CMD_BASE, 12'd100: regf address of descriptor 0 byte 0.
- MAX_CMDS, 8: descriptor slots; pointer wraps modulo MAX_CMDS.
- HDR_MODE, 3'd6: MODE code for HDR-DDR.

Ports:
- i_sys_clk  in  1  system clock
- i_sys_rst_n  in  1  async active-low reset
- i_fetch_start  in  1  1-cycle pulse from I3C engine: begin sequence
- i_cmd_count  in  4  descriptors in sequence (0 treated as 1); sampled on start
- i_regf_rd_data  in  8  regf read data, valid 1 cycle after o_regf_rd_en
- o_regf_rd_en  out  1  regf read strobe
- o_regf_addr  out  12  regf read address
- i_ccc_done  in  1  CCC block done pulse (same as HDR engine sees)
- i_ddr_mode_done  in  1  DDR block done pulse
- i_hdrengine_done  in  1  HDR engine sequence-done pulse
- o_hdrengine_en  out  1  HDR engine enable
- o_cp  out  1  command-present bit to HDR engine
- o_toc  out  1  term-of-completion to HDR engine
- o_mode  out  3  mode to HDR engine
- o_ccc_code  out  8  CCC/command byte of active descriptor
- o_tid  out  3  index of active descriptor
- o_fetch_done  out  1  1-cycle pulse: sequence finished cleanly
- o_fetch_err  out  1  sticky error; cleared on next i_fetch_start

Behaviour:
- Descriptor layout: 2 bytes at CMD_BASE + 2*idx.
  - Byte0: [7] CP, [6] TOC, [5:3] MODE, [2:0] reserved.
  - Byte1: CCC code.
- Last descriptor (idx == count-1): TOC is forced to 1 regardless of memory.
- Reset value of all outputs is 0; o_regf_addr resets to CMD_BASE. FSM resets to IDLE; pointer, count and shadow registers reset to 0.
- States and transitions:
  - IDLE: on i_fetch_start, clear o_fetch_err, latch count, idx=0 → RD0.
  - RD0 / RD1: o_regf_rd_en=1 for one cycle with addr of byte0/byte1 → W0 / W1.
  - W0 / W1: capture i_regf_rd_data into the active (first fetch) or shadow (prefetch) register. W0 → RD1; W1 → LAUNCH (first fetch) or RUN (prefetch).
  - LAUNCH: drive o_cp/o_toc/o_mode/o_ccc_code/o_tid from active; o_hdrengine_en=1 → RUN. If active TOC=0, immediately start prefetch of idx+1 (RD0 with shadow target).
  - RUN: holds o_hdrengine_en=1.
- Prefetch and hand-over in RUN:
  - When the shadow becomes valid, o_cp switches to shadow CP the next cycle; o_toc stays at the active TOC.
  - On (i_ccc_done | i_ddr_mode_done) with active TOC=0 and shadow valid: next cycle active ← shadow, idx++, o_toc/o_mode/o_ccc_code/o_tid update, shadow invalidated. If new TOC=0, start a new prefetch.
  - Done while shadow not yet valid: set o_fetch_err, drop o_hdrengine_en → IDLE.
- Termination:
  - On i_hdrengine_done: deassert o_hdrengine_en next cycle, pulse o_fetch_done 1 cycle (unless o_fetch_err) → IDLE.
  - If i_hdrengine_done arrives while a prefetch is in flight, the prefetch is abandoned and no regf strobe is issued after that cycle.
- Index and address arithmetic: idx is 3-bit and wraps modulo MAX_CMDS; address = CMD_BASE + {idx,1'b0} + byte, computed in 12 bits.
- i_fetch_start outside IDLE is ignored.
- A regf read is never issued while another read's data is pending; at most one outstanding read.
- Reset mid-operation: all state is cleared asynchronously; no done pulse is issued.

Decomposition:
- Shared package hdr_pkg: descriptor bit positions (CP_BIT, TOC_BIT, MODE_MSB/LSB), HDR_MODE, CMD_BASE, FSM state encodings.
- One sub-module, hdr_desc_reg: active/shadow descriptor pair with load, promote and valid-flag logic.
- The FSM and address generator stay in the top level.

Test Plan:
- Single cmd: count=1, byte0=8'h40 (CP=0, TOC=1, MODE=0), byte1=8'h00 → reads at 100, 101; o_cp=0, o_toc=1, en high; i_hdrengine_done → o_fetch_done pulse, en low.
- Two-cmd chain: desc0=8'hB0 (CP=1, TOC=0, MODE=6), desc1=8'h70, count=2 → prefetch reads at 102, 103 before done; o_cp flips 1→0 before i_ccc_done; after done o_tid=1, o_toc=1.
- Forced TOC: count=3, all TOC bits 0 → third descriptor presents o_toc=1; sequence ends on i_hdrengine_done.
- Early done: assert i_ddr_mode_done 2 cycles after LAUNCH (prefetch incomplete) → o_fetch_err=1, en low, no o_fetch_done.
- Wrap: count=8 starting from idx 0 → addresses 100..115; idx returns toward 0 without X; o_tid sequences 0..7.
- Reset mid-RUN: drop i_sys_rst_n during prefetch → all outputs 0 immediately; a fresh i_fetch_start restarts reads at address 100.
